// File: rtl/al422_frame_writer.sv
// al422_frame_writer
// Write side of the AL422 frame FIFO. Takes a frame-marked byte stream and
// drives the AL422 write pins (WCK, /WE, /WRST, DATA). Every frame begins with
// a write-pointer reset so the panel reader always finds byte 0 at address 0.
// All outputs come straight from flops; the *_d values computed below are the
// pin levels for the state being entered.
module al422_frame_writer #(
  parameter int unsigned MAX_BYTES   = 393216,
  parameter int unsigned WRST_CYCLES = 4,
  parameter int unsigned CNT_W       = 19
) (
  input  logic             in_clk,
  input  logic             in_nrst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             in_ready,
  output logic             al422_wck_out,
  output logic             al422_wrst_out,
  output logic             al422_we_out,
  output logic [7:0]       al422_data_out,
  output logic             frame_done,
  output logic             overflow,
  output logic [CNT_W-1:0] byte_count
);

  // Legacy-compatible state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRST  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WR_LO = 3'd3;
  localparam logic [2:0] ST_WR_HI = 3'd4;

  // /WRST is held low for WRST_CYCLES full WCK periods, two clocks each.
  localparam int unsigned WRST_CLKS  = 2 * WRST_CYCLES;
  localparam int unsigned WRST_CNT_W = (WRST_CLKS > 2) ? $clog2(WRST_CLKS) : 1;
  localparam logic [WRST_CNT_W-1:0] WRST_LAST = WRST_CNT_W'(WRST_CLKS - 1);
  localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_BYTES);

  // State and pin flops.
  logic [2:0]            state_q, state_d;
  logic [WRST_CNT_W-1:0] wrst_cnt_q, wrst_cnt_d;
  logic                  wck_q, wck_d;
  logic                  wrst_q, wrst_d;
  logic                  we_q, we_d;
  logic [7:0]            data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_W-1:0]      byte_count_q, byte_count_d;

  // Holding register: the accepted byte and its eof flag.
  logic [7:0]            hold_data_q, hold_data_d;
  logic                  hold_eof_q, hold_eof_d;

  // Transition requests raised by the state decode and applied in one place.
  logic                  accept;
  logic                  capture;
  logic                  go_wrst;
  logic                  go_wr_lo;

  assign accept = in_valid & ready_q;

  // Next-state and next-pin computation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d      = state_q;
    wrst_cnt_d   = wrst_cnt_q;
    wck_d        = wck_q;
    wrst_d       = wrst_q;
    we_d         = we_q;
    data_d       = data_q;
    ready_d      = ready_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    byte_count_d = byte_count_q;
    hold_data_d  = hold_data_q;
    hold_eof_d   = hold_eof_q;
    capture      = 1'b0;
    go_wrst      = 1'b0;
    go_wr_lo     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Bytes outside a frame are consumed and dropped with no pin activity.
        ready_d = 1'b1;
        if (accept && in_sof) begin
          capture = 1'b1;
          go_wrst = 1'b1;
        end
      end

      ST_WRST: begin
        if (wrst_cnt_q == WRST_LAST) begin
          go_wr_lo = 1'b1;
        end else begin
          wrst_cnt_d = wrst_cnt_q + WRST_CNT_W'(1);
          wck_d      = ~wck_q;
        end
      end

      ST_WAIT: begin
        if (accept) begin
          capture  = 1'b1;
          go_wrst  = in_sof;
          go_wr_lo = ~in_sof;
        end
      end

      ST_WR_LO: begin
        // Rising WCK edge: the AL422 latches the byte if /WE is low.
        state_d = ST_WR_HI;
        wck_d   = 1'b1;
        ready_d = ~hold_eof_q;
        if (!we_q) begin
          byte_count_d = byte_count_q + CNT_W'(1);
        end
      end

      ST_WR_HI: begin
        if (hold_eof_q) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          wck_d        = 1'b0;
          we_d         = 1'b1;
          ready_d      = 1'b1;
        end else if (accept) begin
          capture  = 1'b1;
          go_wrst  = in_sof;
          go_wr_lo = ~in_sof;
        end else begin
          state_d = ST_WAIT;
          wck_d   = 1'b0;
          we_d    = 1'b1;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        wck_d   = 1'b0;
        wrst_d  = 1'b1;
        we_d    = 1'b1;
        ready_d = 1'b0;
      end
    endcase

    if (capture) begin
      hold_data_d = in_data;
      hold_eof_d  = in_eof;
    end

    // Frame start: a new write-pointer reset; a frame in progress is abandoned.
    if (go_wrst) begin
      state_d      = ST_WRST;
      wrst_cnt_d   = '0;
      wrst_d       = 1'b0;
      wck_d        = 1'b0;
      we_d         = 1'b1;
      ready_d      = 1'b0;
      byte_count_d = '0;
      overflow_d   = 1'b0;
    end

    // Present the held byte with WCK low; a full FIFO turns the write into a drop.
    if (go_wr_lo) begin
      state_d = ST_WR_LO;
      wrst_d  = 1'b1;
      wck_d   = 1'b0;
      ready_d = 1'b0;
      data_d  = hold_data_d;
      if (byte_count_q == MAX_CNT) begin
        we_d       = 1'b1;
        overflow_d = 1'b1;
      end else begin
        we_d = 1'b0;
      end
    end
  end

  // State, pin and holding registers; reset forces the pins idle at once.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      // NOTE: the holding register is reset as well; it is a handful of
      // flops, not a RAM, and a known value keeps the data pins defined.
      state_q      <= ST_IDLE;
      wrst_cnt_q   <= '0;
      wck_q        <= 1'b0;
      wrst_q       <= 1'b1;
      we_q         <= 1'b1;
      data_q       <= '0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
      hold_data_q  <= '0;
      hold_eof_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q      <= state_d;
      wrst_cnt_q   <= wrst_cnt_d;
      wck_q        <= wck_d;
      wrst_q       <= wrst_d;
      we_q         <= we_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
      hold_data_q  <= hold_data_d;
      hold_eof_q   <= hold_eof_d;
    end
  end

  assign in_ready       = ready_q;
  assign al422_wck_out  = wck_q;
  assign al422_wrst_out = wrst_q;
  assign al422_we_out   = we_q;
  assign al422_data_out = data_q;
  assign frame_done     = frame_done_q;
  assign overflow       = overflow_q;
  assign byte_count     = byte_count_q;

endmodule

// File: tb/tb_al422_frame_writer.sv
// Testbench for al422_frame_writer. Two instances share the stimulus: one with
// the default FIFO size and one with an 8-byte FIFO for the overflow case;
// sel_small picks which one the monitor and checks observe. Bytes expected on
// the AL422 pins are queued when the stream accepts them and popped by the pin
// monitor on each latching WCK rise.
module tb_al422_frame_writer;

  localparam int DEF_MAX   = 393216;
  localparam int SMALL_MAX = 8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sof;
  logic        in_eof;

  logic        d_ready, d_wck, d_wrst, d_we, d_fd, d_ovf;
  logic [7:0]  d_data;
  logic [18:0] d_bc;
  logic        s_ready, s_wck, s_wrst, s_we, s_fd, s_ovf;
  logic [7:0]  s_data;
  logic [3:0]  s_bc;

  bit          sel_small;
  logic        mon_ready, mon_wck, mon_wrst, mon_we, mon_fd, mon_ovf;
  logic [7:0]  mon_data;
  logic [18:0] mon_bc;

  int checks;
  int errors;

  // Scoreboard and reference model state.
  logic [7:0] exp_q[$];
  bit         m_in_frame;
  int         m_count;

  // Pin monitor counters.
  int cyc;
  int writes;
  int wrst_rises;
  int wrst_low_clks;
  int fd_pulses;
  int activity;
  int first_write_cyc;
  int last_write_cyc;
  int we_rise_cyc;
  int sof_cyc;
  logic       p_wck, p_wrst, p_we;
  logic [7:0] p_data;

  al422_frame_writer dut (
    .in_clk(clk), .in_nrst(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_eof(in_eof), .in_ready(d_ready),
    .al422_wck_out(d_wck), .al422_wrst_out(d_wrst), .al422_we_out(d_we),
    .al422_data_out(d_data), .frame_done(d_fd), .overflow(d_ovf),
    .byte_count(d_bc)
  );

  al422_frame_writer #(.MAX_BYTES(SMALL_MAX), .WRST_CYCLES(4), .CNT_W(4)) dut_small (
    .in_clk(clk), .in_nrst(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_eof(in_eof), .in_ready(s_ready),
    .al422_wck_out(s_wck), .al422_wrst_out(s_wrst), .al422_we_out(s_we),
    .al422_data_out(s_data), .frame_done(s_fd), .overflow(s_ovf),
    .byte_count(s_bc)
  );

  always_comb begin
    mon_ready = sel_small ? s_ready : d_ready;
    mon_wck   = sel_small ? s_wck   : d_wck;
    mon_wrst  = sel_small ? s_wrst  : d_wrst;
    mon_we    = sel_small ? s_we    : d_we;
    mon_fd    = sel_small ? s_fd    : d_fd;
    mon_ovf   = sel_small ? s_ovf   : d_ovf;
    mon_data  = sel_small ? s_data  : d_data;
    mon_bc    = sel_small ? {15'd0, s_bc} : d_bc;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Pin monitor, sampled on the falling edge: a WCK rise with /WE low is a write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (p_wck === 1'b0 && mon_wck === 1'b1) begin
        if (p_wrst === 1'b0) wrst_rises++;
        if (p_we === 1'b0) begin
          writes++;
          last_write_cyc = cyc;
          if (writes == 1) first_write_cyc = cyc;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write got data=%h, none expected", p_data);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (p_data !== e) begin
              errors++;
              $display("FAIL write_data got %h expected %h", p_data, e);
            end
          end
        end
      end
      if (p_we === 1'b0 && mon_we === 1'b1) we_rise_cyc = cyc;
      if (mon_wrst !== 1'b1) wrst_low_clks++;
      if (mon_fd !== 1'b0) fd_pulses++;
      if (mon_wck !== 1'b0 || mon_we !== 1'b1 || mon_wrst !== 1'b1) activity++;
    end
    p_wck  = mon_wck;
    p_wrst = mon_wrst;
    p_we   = mon_we;
    p_data = mon_data;
  end

  // Reference model: which accepted bytes must reach the FIFO.
  task automatic model_accept(input logic [7:0] d, input logic sof, input logic eof);
    int max_b;
    max_b = sel_small ? SMALL_MAX : DEF_MAX;
    if (sof) begin
      m_in_frame = 1'b1;
      m_count    = 0;
      sof_cyc    = cyc;
    end
    if (m_in_frame) begin
      if (m_count < max_b) begin
        exp_q.push_back(d);
        m_count++;
      end
      if (eof) m_in_frame = 1'b0;
    end
  endtask

  task automatic clear_mon();
    writes = 0; wrst_rises = 0; wrst_low_clks = 0; fd_pulses = 0; activity = 0;
    first_write_cyc = -1; last_write_cyc = -1; we_rise_cyc = -1;
  endtask

  // Present one byte and hold it until accepted; in_valid stays high afterwards.
  task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof);
    int n;
    n = 0;
    in_data = d; in_sof = sof; in_eof = eof; in_valid = 1'b1;
    @(negedge clk);
    while (mon_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (mon_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout byte=%h in_ready=%b after %0d cycles, expected 1", d, mon_ready, n);
    end else begin
      @(posedge clk);
      #1;
      model_accept(d, sof, eof);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_in_frame = 1'b0;
    m_count = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_end(input string name, input int exp_writes, input int exp_fd,
                           input int exp_bc, input logic exp_ovf);
    checks++;
    if (writes !== exp_writes || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes got %0d (queue left %0d) expected %0d", name, writes, exp_q.size(), exp_writes);
    end
    checks++;
    if (fd_pulses !== exp_fd) begin
      errors++;
      $display("FAIL %s_frame_done got %0d pulses expected %0d", name, fd_pulses, exp_fd);
    end
    checks++;
    if (mon_bc !== 19'(exp_bc)) begin
      errors++;
      $display("FAIL %s_byte_count got %0d expected %0d", name, mon_bc, exp_bc);
    end
    checks++;
    if (mon_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s_overflow got %b expected %b", name, mon_ovf, exp_ovf);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mon_wck, mon_wrst, mon_we, mon_ready, mon_fd, mon_ovf} !== 6'b011000) begin
      errors++;
      $display("FAIL reset_pins got wck,wrst,we,ready,fd,ovf=%b expected 011000",
               {mon_wck, mon_wrst, mon_we, mon_ready, mon_fd, mon_ovf});
    end
    checks++;
    if (mon_data !== 8'h00 || mon_bc !== 19'd0) begin
      errors++;
      $display("FAIL reset_data_count got data=%h count=%0d expected 00 and 0", mon_data, mon_bc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (mon_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_before_clock got %b expected 0", mon_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mon_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after_clock got %b expected 1", mon_ready);
    end
  endtask

  task automatic test_basic_frame();
    clear_mon();
    send_byte(8'h2F, 1'b1, 1'b0);
    send_byte(8'h31, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b1);
    idle(20);
    checks++;
    if (wrst_low_clks !== 8 || wrst_rises !== 4) begin
      errors++;
      $display("FAIL basic_wrst got low_clks=%0d rises=%0d expected 8 and 4", wrst_low_clks, wrst_rises);
    end
    check_end("basic", 3, 1, 3, 1'b0);
  endtask

  task automatic test_no_sof();
    do_reset();
    clear_mon();
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b0, (i == 4));
    idle(12);
    checks++;
    if (activity !== 0) begin
      errors++;
      $display("FAIL no_sof_pins got %0d active cycles expected 0", activity);
    end
    check_end("no_sof", 0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    clear_mon();
    for (int i = 0; i < 12; i++) send_byte(8'h50 + 8'(i), (i == 0), (i == 11));
    idle(12);
    checks++;
    if (first_write_cyc !== sof_cyc + 9 || last_write_cyc !== sof_cyc + 31) begin
      errors++;
      $display("FAIL b2b_write_timing got first=+%0d last=+%0d expected +9 and +31",
               first_write_cyc - sof_cyc, last_write_cyc - sof_cyc);
    end
    checks++;
    if (we_rise_cyc !== sof_cyc + 32) begin
      errors++;
      $display("FAIL b2b_last_we_end got +%0d expected +32", we_rise_cyc - sof_cyc);
    end
    check_end("b2b", 12, 1, 12, 1'b0);
  endtask

  task automatic test_overflow();
    sel_small = 1'b1;
    clear_mon();
    for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i), (i == 0), (i == 9));
    idle(12);
    check_end("ovf", 8, 1, 8, 1'b1);
    clear_mon();
    send_byte(8'h60, 1'b1, 1'b0);
    checks++;
    if (mon_ovf !== 1'b0 || mon_bc !== 19'd0) begin
      errors++;
      $display("FAIL ovf_clear_at_sof got ovf=%b count=%0d expected 0 and 0", mon_ovf, mon_bc);
    end
    send_byte(8'h61, 1'b0, 1'b1);
    idle(12);
    check_end("ovf_next", 2, 1, 2, 1'b0);
    sel_small = 1'b0;
  endtask

  task automatic test_sof_restart();
    clear_mon();
    send_byte(8'h81, 1'b1, 1'b0);
    send_byte(8'h82, 1'b0, 1'b0);
    send_byte(8'h83, 1'b0, 1'b0);
    send_byte(8'h84, 1'b1, 1'b0);
    checks++;
    if (mon_bc !== 19'd0) begin
      errors++;
      $display("FAIL restart_count_clear got %0d expected 0", mon_bc);
    end
    send_byte(8'h85, 1'b0, 1'b0);
    checks++;
    if (mon_bc !== 19'd1) begin
      errors++;
      $display("FAIL restart_count_first got %0d expected 1", mon_bc);
    end
    send_byte(8'h86, 1'b0, 1'b1);
    idle(12);
    checks++;
    if (wrst_rises !== 8) begin
      errors++;
      $display("FAIL restart_wrst_rises got %0d expected 8", wrst_rises);
    end
    check_end("restart", 6, 1, 3, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    int n;
    clear_mon();
    send_byte(8'hA5, 1'b1, 1'b0);
    in_valid = 1'b0; in_sof = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(mon_wck === 1'b1 && mon_wrst === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mon_wck, mon_we, mon_wrst, mon_ready} !== 4'b0110) begin
      errors++;
      $display("FAIL midreset_pins got wck,we,wrst,ready=%b expected 0110",
               {mon_wck, mon_we, mon_wrst, mon_ready});
    end
    checks++;
    if (writes !== 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_partial got writes=%0d expected 1", writes);
    end
    do_reset();
    clear_mon();
    for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b0, 1'b0);
    idle(6);
    checks++;
    if (activity !== 0 || writes !== 0) begin
      errors++;
      $display("FAIL midreset_needs_sof got active=%0d writes=%0d expected 0 and 0", activity, writes);
    end
    send_byte(8'h5A, 1'b1, 1'b1);
    idle(16);
    check_end("midreset_recover", 1, 1, 1, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; sel_small = 1'b0;
    m_in_frame = 1'b0; m_count = 0; sof_cyc = 0;
    clear_mon();
    test_reset();
    test_basic_frame();
    test_no_sof();
    test_back_to_back();
    test_overflow();
    test_sof_restart();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
